// File: rtl/debug_frame_tx.sv
// Frames a captured pipeline debug snapshot for a byte-wide UART transmitter:
// SOF byte, payload bytes LSB-first, then an XOR checksum of the payload.
module debug_frame_tx #(
  parameter int         DATA_W = 2558,
  parameter logic [7:0] SOF    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_tx_done,
  output logic              o_tx_start,
  output logic [7:0]        o_tx_byte,
  output logic              o_busy,
  output logic              o_done
);

  localparam int NBYTES = (DATA_W + 7) / 8;
  localparam int SH_W   = NBYTES * 8;
  localparam int CNT_W  = $clog2(NBYTES + 2);
  localparam logic [CNT_W-1:0] LAST_PAY = CNT_W'(NBYTES);
  localparam logic [CNT_W-1:0] CSUM_IDX = CNT_W'(NBYTES + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, FINISH} state_t;

  state_t            state;
  logic [SH_W-1:0]   shadow;
  logic [CNT_W-1:0]  count;
  logic [7:0]        csum;
  logic [SH_W-1:0]   shadow_shifted;
  logic [7:0]        csum_next;

  // The shadow shifts right one byte per completed payload byte, so the
  // byte being sent is always shadow[7:0] and no wide index mux is needed.
  assign shadow_shifted = shadow >> 8;
  assign csum_next      = csum ^ shadow[7:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shadow     <= '0;
      count      <= '0;
      csum       <= '0;
      o_tx_start <= 1'b0;
      o_tx_byte  <= 8'h00;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            shadow     <= SH_W'(i_data);
            count      <= '0;
            csum       <= '0;
            o_tx_start <= 1'b1;
            o_tx_byte  <= SOF;
            o_busy     <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          o_tx_start <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (i_tx_done) begin
            if (count == CSUM_IDX) begin
              o_done <= 1'b1;
              state  <= FINISH;
            end else begin
              count      <= count + 1'b1;
              o_tx_start <= 1'b1;
              state      <= SEND;
              if (count == '0) begin
                o_tx_byte <= shadow[7:0];
              end else begin
                // Fold the payload byte just completed; after the last one the
                // folded value itself is the checksum byte to send.
                shadow    <= shadow_shifted;
                csum      <= csum_next;
                o_tx_byte <= (count == LAST_PAY) ? csum_next : shadow_shifted[7:0];
              end
            end
          end
        end
        FINISH: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/debug_frame_tx.md
DEBUG_FRAME_TX -- requirements
Module: debug_frame_tx

Interface
REQ-001 Parameter DATA_W, default 2558, is the width of the pipeline debug snapshot bus.
REQ-002 Parameter SOF, default 8'hA5, is the start-of-frame byte sent before the payload.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 i_start  input  1  single-cycle request to capture and send one snapshot.
REQ-006 i_data  input  DATA_W  pipeline debug snapshot (register file, memory, latches, PC).
REQ-007 i_tx_done  input  1  single-cycle pulse from the UART transmitter: current byte fully shifted out.
REQ-008 o_tx_start  output  1  single-cycle pulse telling the UART transmitter to load o_tx_byte.
REQ-009 o_tx_byte  output  8  byte presented to the UART transmitter.
REQ-010 o_busy  output  1  high from the cycle after an accepted i_start until the frame completes.
REQ-011 o_done  output  1  single-cycle pulse when the last frame byte has completed.

Function
REQ-012 NBYTES = ceil(DATA_W/8); the frame is SOF, then NBYTES payload bytes, then one checksum byte, for NBYTES+2 bytes total (322 at the default width).
REQ-013 Payload order: byte 0 = i_data[7:0], byte k = i_data[8k+7:8k]; bits above DATA_W-1 in the last byte are transmitted as 0.
REQ-014 Checksum = XOR of all NBYTES payload bytes; SOF is excluded.
REQ-015 The FSM has states IDLE, SEND, WAIT, FINISH.
REQ-016 IDLE: i_start=1 captures i_data into an internal shadow register, clears the checksum and byte counter, and moves to SEND.
REQ-017 SEND: o_tx_start=1 and o_tx_byte = the current byte for exactly one cycle, then the FSM moves to WAIT.
REQ-018 WAIT: on i_tx_done=1, the counter increments and the payload byte is folded into the checksum. The FSM then moves to SEND if bytes remain, otherwise to FINISH.
REQ-019 FINISH: o_done=1 for one cycle, then the FSM moves to IDLE.
REQ-020 Latency: an accepted i_start at cycle t gives o_tx_start with SOF at t+1.
REQ-021 Latency: i_tx_done at cycle u gives the next o_tx_start at u+1, or o_done at u+1 after the checksum byte.
REQ-022 o_busy=1 in SEND, WAIT and FINISH; o_busy=0 in IDLE, including the o_done cycle+1.
REQ-023 o_tx_byte holds stable from its o_tx_start cycle until the matching i_tx_done.
REQ-024 i_start while not in IDLE is ignored and is not queued.
REQ-025 Changes on i_data after capture do not affect the frame in progress.
REQ-026 i_tx_done in IDLE, SEND or FINISH is ignored.
REQ-027 The FSM waits in WAIT indefinitely; there is no timeout.
REQ-028 Byte counter width = clog2(NBYTES+2); it resets to 0 on each accepted i_start and never wraps within a frame.

Reset
REQ-029 rst=0 asynchronously forces IDLE with o_tx_start=0, o_tx_byte=8'h00, o_busy=0, o_done=0, counter=0, checksum=0.
REQ-030 Reset mid-frame aborts the frame: no further bytes, and no o_done.
REQ-031 After rst returns to 1, the block accepts the next i_start normally.

Verification
REQ-032 DATA_W=12, i_data=12'hABC, i_start, i_tx_done 5 cycles after each o_tx_start -> bytes A5, BC, 0A, B6, then one o_done; o_busy high for the whole frame.
REQ-033 Default width, random i_data, i_tx_done delays randomized 1..20 cycles -> exactly 322 o_tx_start pulses, payload matching i_data LSB-first, correct XOR checksum, one o_done.
REQ-034 i_start pulsed again mid-frame, and i_data changed after capture -> frame unchanged and no second frame starts.
REQ-035 i_tx_done pulsed while in IDLE, then i_start -> first o_tx_start carries A5 and the counter starts at 0.
REQ-036 rst asserted in WAIT after the payload byte-3 o_tx_start -> all outputs zero immediately and no o_done; new i_start after release -> a complete correct frame.
REQ-037 Across all scenarios, o_tx_byte never changes between an o_tx_start and its i_tx_done.
